// File: rtl/hazard_tracker.sv
// D-stage hazard unit: in-flight writer scoreboard, stall and D-forward selects, MDU occupancy.
// Define HAZARD_MDU_EN to build the multiply/divide busy counter and its stall term.
module hazard_tracker #(
  parameter int NSTAGE  = 3,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [4:0]                       a1,
  input  logic [4:0]                       a2,
  input  logic [TW-1:0]                    Tuse_rs,
  input  logic [TW-1:0]                    Tuse_rt,
  input  logic                             D_we,
  input  logic [4:0]                       D_a3,
  input  logic [TW-1:0]                    D_Tnew,
  input  logic                             D_md_start,
  input  logic                             D_md_div,
  input  logic                             D_md_use,
  output logic                             stall,
  output logic [$clog2(NSTAGE+1)-1:0]      fwd_rs_sel,
  output logic [$clog2(NSTAGE+1)-1:0]      fwd_rt_sel,
  output logic                             md_busy
);

  localparam int SW = $clog2(NSTAGE + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  typedef struct packed {
    logic          hit;
    logic [SW-1:0] sel;
    logic [TW-1:0] tnew;
  } match_t;

  logic          sb_we   [NSTAGE];
  logic [4:0]    sb_a3   [NSTAGE];
  logic [TW-1:0] sb_tnew [NSTAGE];

  match_t rs_match;
  match_t rt_match;
  logic   rs_hazard;
  logic   rt_hazard;
  logic   md_hazard;

  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Scan oldest to youngest so the youngest matching writer wins.
  function automatic match_t find_writer(input logic [4:0] addr);
    match_t m;
    m = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (sb_we[i] && (sb_a3[i] == addr) && (addr != 5'd0)) begin
        m.hit  = 1'b1;
        m.sel  = SW'(i + 1);
        m.tnew = sb_tnew[i];
      end
    end
    return m;
  endfunction

  function automatic logic gpr_hazard(input match_t m, input logic [TW-1:0] tuse);
    return m.hit && (tuse != TUSE_NONE) && (m.tnew > tuse);
  endfunction

  function automatic logic [SW-1:0] fwd_select(input match_t m);
    return (m.hit && (m.tnew == '0)) ? m.sel : '0;
  endfunction

  always_comb begin
    rs_match   = find_writer(a1);
    rt_match   = find_writer(a2);
    rs_hazard  = gpr_hazard(rs_match, Tuse_rs);
    rt_hazard  = gpr_hazard(rt_match, Tuse_rt);
    fwd_rs_sel = fwd_select(rs_match);
    fwd_rt_sel = fwd_select(rt_match);
  end

  assign stall = rs_hazard | rt_hazard | md_hazard;

  // ---- scoreboard shift: D -> E -> M -> W, bubble on stall ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTAGE; i++) begin
        sb_we[i]   <= 1'b0;
        sb_a3[i]   <= 5'd0;
        sb_tnew[i] <= '0;
      end
    end else begin
      sb_we[0]   <= stall ? 1'b0 : D_we;
      sb_a3[0]   <= stall ? 5'd0 : D_a3;
      sb_tnew[0] <= stall ? '0   : D_Tnew;
      for (int i = 1; i < NSTAGE; i++) begin
        sb_we[i]   <= sb_we[i-1];
        sb_a3[i]   <= sb_a3[i-1];
        sb_tnew[i] <= tnew_dec(sb_tnew[i-1]);
      end
    end
  end

`ifdef HAZARD_MDU_EN
  localparam int CW = $clog2(DIV_LAT + 1);

  logic [CW-1:0] md_cnt;

  // ---- MDU occupancy: a stalled start must not load the counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (D_md_start && !stall) begin
      md_cnt <= D_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy   = (md_cnt != '0);
  assign md_hazard = D_md_use & md_busy;
`else
  localparam int md_unused_lat = MUL_LAT + DIV_LAT;
  logic md_unused;

  assign md_unused = ^{D_md_start, D_md_div, D_md_use};
  assign md_busy   = 1'b0;
  assign md_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Scenario bench for hazard_tracker: each task queues D-stage steps, pushes the
// expected {stall, fwd_rs_sel, fwd_rt_sel, md_busy} and checks it on the falling edge.
module tb_hazard_tracker;

`ifdef HAZARD_MDU_EN
  localparam logic MDU = 1'b1;
`else
  localparam logic MDU = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] a1, a2, D_a3;
  logic [1:0] Tuse_rs, Tuse_rt, D_Tnew;
  logic       D_we, D_md_start, D_md_div, D_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [5:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       chk;
    logic       we;
    logic [4:0] a3;
    logic [1:0] tn;
    logic [4:0] a1;
    logic [1:0] tr;
    logic [4:0] a2;
    logic [1:0] tt;
    logic [2:0] md;   // {start, div, use}
    logic [5:0] exp;
    string      tag;
  } step_t;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t  exp_q[$];
  step_t sq[$];

  hazard_tracker #(.NSTAGE(3), .TW(2), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset),
    .a1(a1), .a2(a2), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
    .D_we(D_we), .D_a3(D_a3), .D_Tnew(D_Tnew),
    .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;
  assign obs = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};

  function automatic logic [5:0] ex(input logic s, input logic [1:0] rs, input logic [1:0] rt, input logic b);
    return {s, rs, rt, b};
  endfunction

  function automatic step_t st(input string tag, input logic we, input logic [4:0] a3, input logic [1:0] tn,
                               input logic [4:0] ra, input logic [1:0] tr, input logic [4:0] rb,
                               input logic [1:0] tt, input logic [2:0] md, input logic [5:0] e);
    step_t s;
    s.rst = 1'b0; s.chk = 1'b1; s.we = we; s.a3 = a3; s.tn = tn;
    s.a1 = ra; s.tr = tr; s.a2 = rb; s.tt = tt; s.md = md; s.exp = e; s.tag = tag;
    return s;
  endfunction

  function automatic step_t rst_step(input logic [4:0] ra, input logic [1:0] tr);
    step_t s;
    s = st("reset", 1'b0, 5'd0, 2'd0, ra, tr, 5'd0, 2'd3, 3'b000, 6'd0);
    s.rst = 1'b1;
    s.chk = 1'b0;
    return s;
  endfunction

  task automatic apply(input step_t s);
    reset = s.rst; D_we = s.we; D_a3 = s.a3; D_Tnew = s.tn;
    a1 = s.a1; Tuse_rs = s.tr; a2 = s.a2; Tuse_rt = s.tt;
    D_md_start = s.md[2]; D_md_div = s.md[1]; D_md_use = s.md[0];
  endtask

  task automatic test_reset();
    exp_t e;
    sq = {};
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("rst_idle", 0, 0, 0, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("rst_consumer", 0, 0, 0, 1, 0, 2, 0, 3'b001, ex(0, 0, 0, 0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      if (sq[i].chk) exp_q.push_back('{sq[i].tag, sq[i].exp});
      @(negedge clk);
      if (sq[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s step %0d got %b want %b", e.tag, i, obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    sq = {};
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("lu_lw",     1, 1, 2, 2, 1, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("lu_beq_s1", 0, 0, 0, 1, 0, 0, 0, 3'b000, ex(1, 0, 0, 0)));
    sq.push_back(st("lu_beq_s2", 0, 0, 0, 1, 0, 0, 0, 3'b000, ex(1, 0, 0, 0)));
    sq.push_back(st("lu_beq_go", 0, 0, 0, 1, 0, 0, 0, 3'b000, ex(0, 3, 0, 0)));
    sq.push_back(st("lu_after",  0, 0, 0, 1, 0, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      if (sq[i].chk) exp_q.push_back('{sq[i].tag, sq[i].exp});
      @(negedge clk);
      if (sq[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s step %0d got %b want %b", e.tag, i, obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_store();
    exp_t e;
    sq = {};
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("as_addu",  1, 3, 1, 1, 1, 2, 1, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("as_sw",    0, 0, 0, 0, 3, 3, 2, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("as_sw_m",  0, 0, 0, 0, 3, 3, 0, 3'b000, ex(0, 0, 2, 0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      if (sq[i].chk) exp_q.push_back('{sq[i].tag, sq[i].exp});
      @(negedge clk);
      if (sq[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s step %0d got %b want %b", e.tag, i, obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    exp_t e;
    sq = {};
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("yp_ori",   1, 5, 1, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("yp_lw",    1, 5, 2, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("yp_use_s", 0, 0, 0, 5, 1, 0, 3, 3'b000, ex(1, 0, 0, 0)));
    sq.push_back(st("yp_use_g", 0, 0, 0, 5, 1, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("yp_use_w", 0, 0, 0, 5, 1, 0, 3, 3'b000, ex(0, 3, 0, 0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      if (sq[i].chk) exp_q.push_back('{sq[i].tag, sq[i].exp});
      @(negedge clk);
      if (sq[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s step %0d got %b want %b", e.tag, i, obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_and_unused();
    exp_t e;
    sq = {};
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("z_lw0",    1, 0, 2, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("z_use0",   0, 0, 0, 0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("z_use0b",  0, 0, 0, 0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("z_use0c",  0, 0, 0, 0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("u_lw7",    1, 7, 2, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("u_nouse",  0, 0, 0, 7, 3, 7, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("f_jal",    1, 31, 0, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("f_e_both", 0, 0, 0, 31, 0, 31, 0, 3'b000, ex(0, 1, 1, 0)));
    sq.push_back(st("f_m_rt",   0, 0, 0, 0, 0, 31, 0, 3'b000, ex(0, 0, 2, 0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      if (sq[i].chk) exp_q.push_back('{sq[i].tag, sq[i].exp});
      @(negedge clk);
      if (sq[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s step %0d got %b want %b", e.tag, i, obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mdu();
    exp_t e;
    sq = {};
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("md_mult", 0, 0, 0, 8, 0, 9, 0, 3'b101, ex(0, 0, 0, 0)));
    for (int k = 0; k < 5; k++)
      sq.push_back(st("md_mfhi_m", 1, 2, 1, 0, 3, 0, 3, 3'b001, ex(MDU, 0, 0, MDU)));
    sq.push_back(st("md_mfhi_m_go", 1, 2, 1, 0, 3, 0, 3, 3'b001, ex(0, 0, 0, 0)));
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("md_div", 0, 0, 0, 8, 0, 9, 0, 3'b111, ex(0, 0, 0, 0)));
    for (int k = 0; k < 10; k++)
      sq.push_back(st("md_mfhi_d", 1, 2, 1, 0, 3, 0, 3, 3'b001, ex(MDU, 0, 0, MDU)));
    sq.push_back(st("md_mfhi_d_go", 1, 2, 1, 0, 3, 0, 3, 3'b001, ex(0, 0, 0, 0)));
    // A start held by a GPR stall must not occupy the MDU until it is accepted.
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("ms_lw",    1, 1, 2, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("ms_st1",   0, 0, 0, 1, 0, 0, 0, 3'b101, ex(1, 0, 0, 0)));
    sq.push_back(st("ms_st2",   0, 0, 0, 1, 0, 0, 0, 3'b101, ex(1, 0, 0, 0)));
    sq.push_back(st("ms_go",    0, 0, 0, 1, 0, 0, 0, 3'b101, ex(0, 3, 0, 0)));
    sq.push_back(st("ms_busy",  0, 0, 0, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, MDU)));
    foreach (sq[i]) begin
      apply(sq[i]);
      if (sq[i].chk) exp_q.push_back('{sq[i].tag, sq[i].exp});
      @(negedge clk);
      if (sq[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s step %0d got %b want %b", e.tag, i, obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    sq = {};
    sq.push_back(rst_step(5'd0, 2'd3));
    sq.push_back(st("rm_mult", 0, 0, 0, 0, 3, 0, 3, 3'b101, ex(0, 0, 0, 0)));
    sq.push_back(st("rm_lw",   1, 1, 2, 0, 3, 0, 3, 3'b000, ex(0, 0, 0, MDU)));
    sq.push_back(st("rm_beq",  0, 0, 0, 1, 0, 0, 0, 3'b000, ex(1, 0, 0, MDU)));
    sq.push_back(rst_step(5'd1, 2'd0));
    sq.push_back(st("rm_post",  0, 0, 0, 1, 0, 0, 0, 3'b000, ex(0, 0, 0, 0)));
    sq.push_back(st("rm_post2", 0, 0, 0, 1, 0, 0, 0, 3'b001, ex(0, 0, 0, 0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      if (sq[i].chk) exp_q.push_back('{sq[i].tag, sq[i].exp});
      @(negedge clk);
      if (sq[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s step %0d got %b want %b", e.tag, i, obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; D_we = 1'b0; D_a3 = 5'd0; D_Tnew = 2'd0;
    a1 = 5'd0; a2 = 5'd0; Tuse_rs = 2'd3; Tuse_rt = 2'd3;
    D_md_start = 1'b0; D_md_div = 1'b0; D_md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_alu_store();
    test_youngest();
    test_zero_and_unused();
    test_mdu();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
